// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer feeding decode/execute.
// The next PC comes verbatim from BranchUnit; a misaligned next PC halts fetch until reset.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imemReqValid,
    output logic [ADDR_WIDTH-1:0] imemReqAddr,
    input  logic                  imemReqReady,
    input  logic                  imemRspValid,
    input  logic [INSN_WIDTH-1:0] imemRspInsn,
    output logic                  insnValid,
    output logic [INSN_WIDTH-1:0] insnOut,
    output logic [ADDR_WIDTH-1:0] insnPC,
    input  logic                  insnReady,
    input  logic                  nextPcValid,
    input  logic [ADDR_WIDTH-1:0] nextPc,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  retiredCount
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HAND,
        S_EXEC,
        S_HALT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;
    logic                  fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_valid_q, req_valid_d;
    logic                  insn_valid_q, insn_valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        // Each state looks only at its own qualifying input, so stray inputs are dropped.
        case (state_q)
            S_REQ:  if (imemReqReady) state_d = S_WAIT;
            S_WAIT: begin
                if (imemRspValid) begin
                    insn_d  = imemRspInsn;
                    state_d = S_HAND;
                end
            end
            S_HAND: if (insnReady) state_d = S_EXEC;
            S_EXEC: begin
                if (nextPcValid) begin
                    if (nextPc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = nextPc;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        req_valid_d  = (state_d == S_REQ);
        insn_valid_d = (state_d == S_HAND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            insn_q       <= '0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
            req_valid_q  <= 1'b1;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
            req_valid_q  <= req_valid_d;
            insn_valid_q <= insn_valid_d;
        end
    end

    assign imemReqValid = req_valid_q;
    assign imemReqAddr  = pc_q;
    assign insnValid    = insn_valid_q;
    assign insnOut      = insn_q;
    assign insnPC       = pc_q;
    assign fault        = fault_q;
    assign retiredCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_unit;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRspValid;
    logic [31:0] imemRspInsn;
    logic        insnValid;
    logic [31:0] insnOut;
    logic [31:0] insnPC;
    logic        insnReady;
    logic        nextPcValid;
    logic [31:0] nextPc;
    logic        fault;
    logic [CW-1:0] retiredCount;

    int n_pass = 0;
    int n_total = 0;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .INSN_WIDTH(32),
        .RESET_PC  (32'h0),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imemReqValid(imemReqValid),
        .imemReqAddr (imemReqAddr),
        .imemReqReady(imemReqReady),
        .imemRspValid(imemRspValid),
        .imemRspInsn (imemRspInsn),
        .insnValid   (insnValid),
        .insnOut     (insnOut),
        .insnPC      (insnPC),
        .insnReady   (insnReady),
        .nextPcValid (nextPcValid),
        .nextPc      (nextPc),
        .fault       (fault),
        .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: where the instruction is in its life (fetching, awaiting data,
    // offered to decode, executing, halted), plus pc / insn / count / fault.
    int          ph;
    logic [31:0] m_pc;
    logic [31:0] m_insn;
    int          m_cnt;
    bit          m_fault;
    bit          live = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; m_pc = 32'h0; m_insn = 32'h0; m_cnt = 0; m_fault = 0; live = 1;
        end else if (live) begin
            if (ph == 0) begin
                if (imemReqReady) ph = 1;
            end else if (ph == 1) begin
                if (imemRspValid) begin m_insn = imemRspInsn; ph = 2; end
            end else if (ph == 2) begin
                if (insnReady) ph = 3;
            end else if (ph == 3) begin
                if (nextPcValid) begin
                    if (nextPc % 4 != 0) begin
                        m_fault = 1; ph = 4;
                    end else begin
                        m_pc = nextPc; m_cnt = (m_cnt + 1) % (1 << CW); ph = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("m_reqValid", imemReqValid, (ph == 0));
            check("m_reqAddr", imemReqAddr, m_pc);
            check("m_insnValid", insnValid, (ph == 2));
            check("m_insnOut", insnOut, m_insn);
            check("m_insnPC", insnPC, m_pc);
            check("m_fault", fault, m_fault);
            check("m_count", retiredCount, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic fetch_exec(input logic [31:0] insn, input logic [31:0] npc);
        imemReqReady = 1; step();
        imemReqReady = 0; imemRspValid = 1; imemRspInsn = insn; step();
        imemRspValid = 0; insnReady = 1; step();
        insnReady = 0; nextPcValid = 1; nextPc = npc; step();
        nextPcValid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; imemReqReady = 0; imemRspValid = 0; imemRspInsn = 0;
        insnReady = 0; nextPcValid = 0; nextPc = 0;
        step();
        rst = 0; imemReqReady = 1;
        check("rst_reqValid", imemReqValid, 1);
        check("rst_addr", imemReqAddr, 32'h0);
        check("rst_fault", fault, 0);
        check("rst_count", retiredCount, 0);
        check("rst_insnValid", insnValid, 0);
        step();
        imemReqReady = 0; imemRspValid = 1; imemRspInsn = 32'h0000_0013;
        step();
        imemRspValid = 0;
        check("first_insnValid", insnValid, 1);
        check("first_insnOut", insnOut, 32'h13);
        check("first_insnPC", insnPC, 32'h0);
        insnReady = 1; step();
        insnReady = 0; nextPcValid = 1; nextPc = 32'h4; step();
        nextPcValid = 0;
        check("retire1_addr", imemReqAddr, 32'h4);
        check("retire1_count", retiredCount, 1);

        // taken branch and request stall
        fetch_exec(32'h0000_0093, 32'h10);
        check("pc10_addr", imemReqAddr, 32'h10);
        fetch_exec(32'h0400_006f, 32'h40);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", imemReqValid, 1);
            check("stall_addr", imemReqAddr, 32'h40);
        end

        // decode backpressure
        imemReqReady = 1; step();
        imemReqReady = 0; imemRspValid = 1; imemRspInsn = 32'hABCD_0113; step();
        imemRspValid = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_insnValid", insnValid, 1);
            check("bp_insnOut", insnOut, 32'hABCD_0113);
            check("bp_insnPC", insnPC, 32'h40);
            check("bp_reqValid", imemReqValid, 0);
            check("bp_count", retiredCount, 3);
        end

        // misaligned next PC halts
        insnReady = 1; step();
        insnReady = 0; nextPcValid = 1; nextPc = 32'h22; step();
        nextPcValid = 0;
        check("halt_fault", fault, 1);
        check("halt_reqValid", imemReqValid, 0);
        check("halt_pc", imemReqAddr, 32'h40);
        check("halt_count", retiredCount, 3);
        imemReqReady = 1; imemRspValid = 1; insnReady = 1; nextPcValid = 1; nextPc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_sticky", fault, 1);
            check("halt_noreq", imemReqValid, 0);
            check("halt_noinsn", insnValid, 0);
        end
        imemReqReady = 0; imemRspValid = 0; insnReady = 0; nextPcValid = 0;
        rst = 1; step(); rst = 0;
        check("unhalt_fault", fault, 0);
        check("unhalt_addr", imemReqAddr, 32'h0);
        check("unhalt_reqValid", imemReqValid, 1);

        // reset mid-WAIT, stale response dropped
        imemReqReady = 1; step();
        imemReqReady = 0; rst = 1; step();
        rst = 0; imemRspValid = 1; imemRspInsn = 32'hDEAD_BEEF; step();
        imemRspValid = 0;
        check("stale_insnValid", insnValid, 0);
        check("stale_reqValid", imemReqValid, 1);
        check("stale_addr", imemReqAddr, 32'h0);
        check("stale_insnOut", insnOut, 32'h0);

        // response coincident with acceptance is dropped
        imemReqReady = 1; imemRspValid = 1; imemRspInsn = 32'h0000_0BAD; step();
        imemReqReady = 0; imemRspValid = 0; step();
        check("coinc_insnValid", insnValid, 0);
        check("coinc_reqValid", imemReqValid, 0);
        imemRspValid = 1; imemRspInsn = 32'h0000_0077; step();
        imemRspValid = 0;
        check("fresh_insnValid", insnValid, 1);
        check("fresh_insnOut", insnOut, 32'h77);
        insnReady = 1; step();
        insnReady = 0; nextPcValid = 1; nextPc = 32'h4; step();
        nextPcValid = 0;
        check("fresh_count", retiredCount, 1);

        // counter wrap at 2^CW
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 16; i++) begin
            fetch_exec(32'h0000_0013 + i, 32'(4 * (i + 1)));
            if (i == 14) check("wrap_15", retiredCount, 15);
        end
        check("wrap_0", retiredCount, 0);
        check("wrap_addr", imemReqAddr, 32'h40);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
